muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative signed multiply/divide unit fed by the ALU decoder. Execute stage starts it
//  when alucontrol = 4'b1010 (mult) or 4'b1011 (div), with the ALU operands srca/srcb.
//  Results land in the architectural HI/LO registers, which hold until the next op completes.
//  Control stalls the pipeline while busy is high.
// PARAMETERS
//  WIDTH  32  operand width; HI and LO are WIDTH each; product is 2*WIDTH
// PORTS
//  clk         in   1      single clock, all state updates on rising edge
//  reset       in   1      synchronous, active-high
//  start       in   1      request; sampled only in IDLE
//  alucontrol  in   4      1010 = mult, 1011 = div; any other code ignores start
//  a           in   WIDTH  srca (multiplicand / dividend), two's complement
//  b           in   WIDTH  srcb (multiplier / divisor), two's complement
//  busy        out  1      high whenever FSM is not IDLE
//  done        out  1      one-cycle pulse when hi/lo have just been written
//  hi          out  WIDTH  mult: product[2W-1:W]; div: remainder
//  lo          out  WIDTH  mult: product[W-1:0];  div: quotient
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset wins over every other input.
//  Reset during RUN/FIX: op abandoned, no done pulse, hi/lo cleared.
//  FSM states:
//   IDLE: start && alucontrol in {1010,1011} at edge E0 ->
//         latch op, |a|, |b|, sign(a), sign(b); clear accumulators; go to RUN.
//   RUN:  one iteration per edge, E1..E32; counter 0..31; counter==31 -> FIX.
//   FIX:  at E33, apply sign correction, write hi/lo, done<=1; go to IDLE.
//  done: registered; high exactly in the cycle after E33, low otherwise.
//  busy: derived from state. High from after E0 through E33.
//  Latency: fixed 33 edges from start acceptance to hi/lo update, for both ops and all operands.
//  Ignored requests:
//   - start while busy: no effect; latched operands must not change.
//   - start in IDLE with a non-mult/div code: no effect.
//  Mult:
//   - shift-add on magnitudes, 2W-bit accumulator.
//   - final product negated (2W-bit two's complement) iff sign(a)^sign(b).
//  Div:
//   - restoring divide on magnitudes.
//   - quotient negated iff sign(a)^sign(b); remainder takes sign(a), i.e. truncation toward zero.
//  Div by zero (b==0): still 33 cycles; lo=all ones, hi=a unmodified; no sign correction.
//  Overflow (-2^(W-1) / -1): lo=0x80000000, hi=0. No exception is raised.
//  hi/lo are written only in FIX; they hold their value across IDLE and across ignored starts.
// TESTING
//  1 mult a=7, b=-3 -> hi=FFFFFFFF, lo=FFFFFFEB; done exactly 33 edges after start edge; busy high 33 cycles.
//  2 div a=-7, b=2 -> lo=FFFFFFFD, hi=FFFFFFFF; div a=7, b=-2 -> lo=FFFFFFFD, hi=00000001.
//  3 div a=5, b=0 -> lo=FFFFFFFF, hi=00000005 after 33 edges; div a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
//  4 mult a=80000000, b=80000000 -> hi=40000000, lo=00000000;
//    mult a=FFFFFFFF, b=FFFFFFFF -> hi=0, lo=1.
//  5 start during busy with new a/b, and start in IDLE with alucontrol=0010
//    -> result unchanged from the first op; no extra done; hi/lo untouched.
//  6 reset asserted at E10 of a mult -> next cycle busy=0, hi=lo=0, no done;
//    a new div a=100, b=7 then gives lo=14, hi=2.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative signed multiply/divide: shift-add multiply or restoring divide on magnitudes,
// 32 iterations plus one sign-fix cycle, results held in HI/LO until the next completed op.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      counter;
  logic               op_div, sa, sb;
  logic [WIDTH-1:0]   ma, mb;
  logic [2*WIDTH-1:0] acc, sh;
  logic               accept;
  logic [WIDTH:0]     rs, diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   a_mag, b_mag, q, r;

  // Handshake: start is a valid with implicit ready = !busy; a request is taken only in
  // IDLE with a mult/div code, everything else is silently dropped.
  assign accept = (state == IDLE) && start &&
                  ((alucontrol == 4'b1010) || (alucontrol == 4'b1011));

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  assign a_mag    = a[WIDTH-1] ? -a : a;
  assign b_mag    = b[WIDTH-1] ? -b : b;
  assign rs       = {acc[WIDTH-1:0], sh[WIDTH-1]};
  assign diff     = rs - {1'b0, mb};
  assign prod_fix = (sa ^ sb) ? -acc : acc;
  assign q        = sh[WIDTH-1:0];
  assign r        = acc[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (counter == CW'(WIDTH - 1)) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      counter <= '0;
      op_div  <= 1'b0;
      sa      <= 1'b0;
      sb      <= 1'b0;
      ma      <= '0;
      mb      <= '0;
      acc     <= '0;
      sh      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_div  <= alucontrol[0];
            sa      <= a[WIDTH-1];
            sb      <= b[WIDTH-1];
            ma      <= a_mag;
            mb      <= b_mag;
            acc     <= '0;
            sh      <= {{WIDTH{1'b0}}, a_mag};
            counter <= '0;
          end
        end
        RUN: begin
          counter <= counter + 1'b1;
          if (!op_div) begin
            // Multiply: sh holds the shifted multiplicand, mb is consumed LSB first.
            if (mb[0]) acc <= acc + sh;
            sh <= sh << 1;
            mb <= mb >> 1;
          end else if (!diff[WIDTH]) begin
            acc[WIDTH-1:0] <= diff[WIDTH-1:0];
            sh[WIDTH-1:0]  <= {sh[WIDTH-2:0], 1'b1};
          end else begin
            acc[WIDTH-1:0] <= rs[WIDTH-1:0];
            sh[WIDTH-1:0]  <= {sh[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          done <= 1'b1;
          if (!op_div) begin
            {hi, lo} <= prod_fix;
          end else if (mb == '0) begin
            // Divide by zero returns the dividend untouched in HI.
            lo <= '1;
            hi <= sa ? -ma : ma;
          end else begin
            lo <= (sa ^ sb) ? -q : q;
            hi <= sa ? -r : r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
